uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one uart_tx byte interface among P_NUM_REQ requesters.

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx byte interface among P_NUM_REQ
// byte producers. One byte is captured per grant, offered with valid/ready,
// then the arbiter returns to IDLE to pick the next requester.
// Optional feature macro: UART_ARB_LOCK_EN (packet lock keyed on i_req_last).
module uart_tx_arbiter #(
    parameter int unsigned P_NUM_REQ         = 4,
    parameter int unsigned P_UART_DATA_WIDTH = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [P_NUM_REQ-1:0]                   i_req_valid,
    input  logic [P_NUM_REQ*P_UART_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]                   i_req_last,
    output logic [P_NUM_REQ-1:0]                   o_req_ready,
    output logic [P_UART_DATA_WIDTH-1:0]           o_user_tx_data,
    output logic                                   o_user_tx_valid,
    input  logic                                   i_user_tx_ready,
    output logic [$clog2(P_NUM_REQ)-1:0]           o_grant_id,
    output logic                                   o_busy
);

    localparam int unsigned ID_W = $clog2(P_NUM_REQ);
    localparam int unsigned DW   = P_UART_DATA_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [DW-1:0]       data_q, data_d;
    logic [P_NUM_REQ-1:0] ready_q, ready_d;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     cand_id;
    int unsigned         cand;
    logic                lock_act;
    logic                xfer;

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic last_q, last_d;
    assign lock_act = lock_q;
`else
    logic unused_last;
    assign unused_last = ^i_req_last;
    assign lock_act    = 1'b0;
`endif

    assign xfer = (state_q == ST_SEND) && i_user_tx_ready;

    // Round-robin search starting one past the last served requester
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_id    = '0;
        for (int unsigned i = 1; i <= P_NUM_REQ; i++) begin
            cand    = (32'(ptr_q) + i) % P_NUM_REQ;
            cand_id = ID_W'(cand);
            if (!pick_found && i_req_valid[cand_id] && (!lock_act || (cand_id == grant_q))) begin
                pick_found = 1'b1;
                pick_idx   = cand_id;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SEND on a grant, SEND -> IDLE on transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_found) state_d = ST_SEND;
            ST_SEND: if (i_user_tx_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: valid and busy both mean "holding a byte"
    always_comb begin
        o_user_tx_valid = (state_q == ST_SEND);
        o_busy          = (state_q == ST_SEND);
    end

    // Capture on grant, pointer/lock update on transfer
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        ready_d = '0;
`ifdef UART_ARB_LOCK_EN
        lock_d  = lock_q;
        last_d  = last_q;
`endif
        if ((state_q == ST_IDLE) && pick_found) begin
            grant_d = pick_idx;
            data_d  = i_req_data[32'(pick_idx)*DW +: DW];
            ready_d = P_NUM_REQ'(1) << pick_idx;
`ifdef UART_ARB_LOCK_EN
            last_d  = i_req_last[pick_idx];
`endif
        end
        if (xfer) begin
            ptr_d = grant_q;
`ifdef UART_ARB_LOCK_EN
            lock_d = !last_q;
`endif
        end
    end

    // Datapath registers; reset leaves requester 0 first in line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q   <= ID_W'(P_NUM_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            ready_q <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ready_q <= ready_d;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= lock_d;
            last_q  <= last_d;
`endif
        end
    end

    assign o_req_ready    = ready_q;
    assign o_grant_id     = grant_q;
    assign o_user_tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [1:0]     gid;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.P_NUM_REQ(N), .P_UART_DATA_WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
        .o_req_ready(req_ready),
        .o_user_tx_data(tx_data), .o_user_tx_valid(tx_valid), .i_user_tx_ready(tx_ready),
        .o_grant_id(gid), .o_busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester queues: bit 8 = last, bits 7:0 = byte
    logic [8:0] rq [N][$];
    logic [N-1:0] seen = '0;
    int total_pushed;

    // Reference model: one held byte, a round-robin pointer, optional lock owner
    bit           m_busy = 0;
    int           m_ptr  = N - 1;
    int           m_gid  = 0;
    logic [W-1:0] m_data = '0;
    bit           m_last = 0;
    bit           m_lock = 0;
    logic [N-1:0] m_rdy  = '0;

    always @(posedge clk) begin
        int c;
        if (rst) begin
            m_busy = 0; m_ptr = N - 1; m_gid = 0; m_lock = 0; m_rdy = '0;
        end else if (!m_busy) begin
            m_rdy = '0;
            for (int i = 1; i <= N; i++) begin
                c = (m_ptr + i) % N;
                if (req_valid[c] && (!m_lock || c == m_gid)) begin
                    m_busy = 1; m_gid = c;
                    m_data = req_data[c*W +: W];
                    m_last = req_last[c];
                    m_rdy[c] = 1'b1;
                    break;
                end
            end
        end else begin
            m_rdy = '0;
            if (tx_ready) begin
                m_busy = 0;
                m_ptr  = m_gid;
`ifdef UART_ARB_LOCK_EN
                m_lock = !m_last;
`endif
            end
        end
    end

    // Log of bytes the DUT actually handed over (sampled outputs + edge inputs)
    int           log_id [$];
    logic [W-1:0] log_dt [$];
    logic         s_valid = 0;
    logic [1:0]   s_gid = '0;
    logic [W-1:0] s_data = '0;

    always @(posedge clk) begin
        if (s_valid && tx_ready && !rst) begin
            log_id.push_back(int'(s_gid));
            log_dt.push_back(s_data);
        end
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (rq[k].size() > 0);
            req_data[k*W +: W] = (rq[k].size() > 0) ? rq[k][0][7:0] : 8'h00;
            req_last[k] = (rq[k].size() > 0) ? rq[k][0][8] : 1'b0;
        end
    endtask

    task automatic push(input int k, input logic lst, input logic [7:0] b);
        rq[k].push_back({lst, b});
        total_pushed++;
    endtask

    // One clock: compare at negedge, retire accepted bytes, drive next inputs
    task automatic cyc();
        @(negedge clk);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_valid", 32'(tx_valid), 32'(m_busy));
        chk("req_ready", 32'(req_ready), 32'(m_rdy));
        chk("grant_id", 32'(gid), 32'(m_gid));
        if (m_busy) chk("tx_data", 32'(tx_data), 32'(m_data));
        s_valid = tx_valid; s_gid = gid; s_data = tx_data;
        for (int k = 0; k < N; k++)
            if (seen[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        seen = req_ready;
        drive();
    endtask

    function automatic bit pending();
        bit p = m_busy;
        for (int k = 0; k < N; k++) if (rq[k].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drain();
        int n = 0;
        while (pending() && n < 500) begin cyc(); n++; end
        chk("drain_timeout", 32'(pending()), 32'd0);
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) rq[k].delete();
        rst = 1'b1; drive(); cyc(); cyc();
        rst = 1'b0; seen = '0;
        log_id.delete(); log_dt.delete();
    endtask

    initial begin
        int held;
        logic [7:0] exp5 [3];
        rst = 1'b1; tx_ready = 1'b1; total_pushed = 0;
        drive();

        // Reset held two cycles with every requester valid
        for (int k = 0; k < N; k++) push(k, 1'b1, 8'(8'h10 + k));
        drive();
        cyc(); cyc();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc();
        chk("first_grant", 32'(gid), 32'd0);
        chk("first_ready", 32'(req_ready), 32'b0001);
        drain();

        // Single byte from requester 2
        do_reset();
        push(2, 1'b1, 8'hA5); drive();
        drain();
        chk("single_cnt", 32'(log_id.size()), 32'd1);
        if (log_id.size() == 1) begin
            chk("single_id", 32'(log_id[0]), 32'd2);
            chk("single_data", 32'(log_dt[0]), 32'hA5);
        end
        chk("single_busy_after", 32'(busy), 32'd0);

        // All four continuously valid: order 0,1,2,3,0,1 at one byte per 2 cycles
        do_reset();
        for (int k = 0; k < N; k++) for (int j = 0; j < 3; j++) push(k, 1'b1, 8'(16*k + j));
        drive();
        repeat (12) cyc();
        chk("rr_cnt", 32'(log_id.size()), 32'd6);
        for (int i = 0; i < 6 && i < log_id.size(); i++) chk("rr_order", 32'(log_id[i]), 32'(i % N));
        drain();

        // Transmitter stalled 20 cycles with another requester waiting
        do_reset();
        tx_ready = 1'b0;
        push(1, 1'b1, 8'h3C); push(3, 1'b1, 8'h99); drive();
        cyc();
        held = 0;
        repeat (20) begin
            cyc();
            if (tx_valid && tx_data == 8'h3C && req_ready == '0) held++;
        end
        chk("stall_hold", 32'(held), 32'd20);
        tx_ready = 1'b1;
        drain();
        chk("stall_cnt", 32'(log_id.size()), 32'd2);
        if (log_id.size() == 2) begin
            chk("stall_first", 32'(log_dt[0]), 32'h3C);
            chk("stall_second", 32'(log_dt[1]), 32'h99);
        end

        // Two-byte packet from req0 competing with req1
        do_reset();
        push(0, 1'b0, 8'h11); push(0, 1'b1, 8'h22); push(1, 1'b1, 8'h33); drive();
        drain();
`ifdef UART_ARB_LOCK_EN
        exp5[0] = 8'h11; exp5[1] = 8'h22; exp5[2] = 8'h33;
`else
        exp5[0] = 8'h11; exp5[1] = 8'h33; exp5[2] = 8'h22;
`endif
        chk("pkt_cnt", 32'(log_dt.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_dt.size(); i++) chk("pkt_order", 32'(log_dt[i]), 32'(exp5[i]));

        // Reset while a byte is held: byte dropped, pointer back to requester 0 first
        do_reset();
        push(2, 1'b1, 8'h77); drive();
        cyc();
        chk("mid_send_valid", 32'(tx_valid), 32'd1);
        rst = 1'b1; drive();
        cyc();
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        push(3, 1'b1, 8'h44); push(0, 1'b1, 8'h55); drive();
        drain();
        chk("mid_rst_cnt", 32'(log_dt.size()), 32'd2);
        if (log_dt.size() == 2) begin
            chk("mid_rst_first", 32'(log_dt[0]), 32'h55);
            chk("mid_rst_second", 32'(log_dt[1]), 32'h44);
        end

        // Randomized traffic with random transmitter back-pressure
        do_reset();
        total_pushed = 0;
        repeat (800) begin
            for (int k = 0; k < N; k++)
                if (rq[k].size() < 3 && $urandom_range(0, 3) == 0)
                    push(k, 1'($urandom_range(0, 1)), 8'($urandom));
            tx_ready = ($urandom_range(0, 3) != 0);
            drive();
            cyc();
        end
        for (int k = 0; k < N; k++) push(k, 1'b1, 8'($urandom));
        tx_ready = 1'b1; drive();
        drain();
        chk("rand_total", 32'(log_dt.size()), 32'(total_pushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
